// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcode/funct codes, ALU codes and state encoding for the multicycle controller
package mips_ctrl_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] AC_ADD   = 2'b00;
    localparam logic [1:0] AC_SUB   = 2'b01;
    localparam logic [1:0] AC_FUNCT = 2'b10;
    localparam logic [1:0] AC_SLT   = 2'b11;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WRITE, MEM_WB,
        R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, JAL, JR, HALT
    } state_t;

    function automatic logic known_op(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_SLTI, OP_LW, OP_SW};
    endfunction
endpackage

// File: rtl/mips_alu_control.sv
// mips_alu_control: maps the controller's ALU class and the R-type funct field to an ALU operation
module mips_alu_control
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctl,
    output logic       funct_valid
);
    logic [2:0] f_ctl;

    // decode funct; jr is a legal funct but uses no ALU operation of its own
    always_comb begin
        f_ctl = ALU_ADD;
        funct_valid = 1'b1;
        case (funct)
            FN_ADD: f_ctl = ALU_ADD;
            FN_SUB: f_ctl = ALU_SUB;
            FN_AND: f_ctl = ALU_AND;
            FN_OR:  f_ctl = ALU_OR;
            FN_SLT: f_ctl = ALU_SLT;
            FN_JR:  f_ctl = ALU_ADD;
            default: funct_valid = 1'b0;
        endcase
    end

    assign alu_ctl = aluop == AC_ADD ? ALU_ADD :
                     aluop == AC_SUB ? ALU_SUB :
                     aluop == AC_SLT ? ALU_SLT : f_ctl;
endmodule

// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller: multicycle MIPS control FSM driving every datapath strobe from the IR
module mips_multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instruction,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegDst,
    output logic        WriteRegSel,
    output logic        MemtoReg,
    output logic        WriteDataSel,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSrc,
    output logic [2:0]  ALUoperation,
    output logic        InstrDone,
    output logic        Halted
);
    state_t state, next;
    logic [5:0] op, fn;
    logic [1:0] aluop;
    logic [2:0] alu_ctl;
    logic alu_en, funct_valid, illegal, unused_bits;

    assign op = Instruction[31:26];
    assign fn = Instruction[5:0];
    assign unused_bits = ^Instruction[25:6];
    assign illegal = !known_op(op) || (op == OP_RTYPE && !funct_valid);

    mips_alu_control u_alu_control (
        .aluop(aluop),
        .funct(fn),
        .alu_ctl(alu_ctl),
        .funct_valid(funct_valid)
    );

    // states that do not use the ALU drive operation code 000
    assign ALUoperation = alu_en ? alu_ctl : 3'b000;

    // state register; reset aborts whatever instruction is in flight
    always_ff @(posedge clk)
        state <= rst ? FETCH : next;

    // next state and Moore outputs; everything stays 0 while rst is high
    always_comb begin
        next = state;
        PCWrite = 1'b0;
        PCWriteCond = 1'b0;
        IorD = 1'b0;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        IRWrite = 1'b0;
        RegDst = 1'b0;
        WriteRegSel = 1'b0;
        MemtoReg = 1'b0;
        WriteDataSel = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA = 1'b0;
        ALUSrcB = 2'b00;
        PCSrc = 2'b00;
        aluop = AC_ADD;
        alu_en = 1'b0;
        InstrDone = 1'b0;
        Halted = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    ALUSrcB = 2'b01;
                    alu_en = 1'b1;
                    next = DECODE;
                end
                DECODE: begin
                    ALUSrcB = 2'b11;
                    alu_en = 1'b1;
                    case (op)
                        OP_LW, OP_SW:      next = MEM_ADDR;
                        OP_RTYPE:          next = fn == FN_JR ? JR : R_EXEC;
                        OP_BEQ:            next = BRANCH;
                        OP_J:              next = JUMP;
                        OP_JAL:            next = JAL;
                        OP_ADDI, OP_SLTI:  next = I_EXEC;
                        default:           next = FETCH;
                    endcase
                    if (illegal) begin
                        next = TRAP_ON_ILLEGAL ? HALT : FETCH;
                        InstrDone = !TRAP_ON_ILLEGAL;
                    end
                end
                MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    alu_en = 1'b1;
                    next = op == OP_LW ? MEM_READ : MEM_WRITE;
                end
                MEM_READ: begin
                    MemRead = 1'b1;
                    IorD = 1'b1;
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    alu_en = 1'b1;
                    next = MEM_WB;
                end
                MEM_WRITE: begin
                    MemWrite = 1'b1;
                    IorD = 1'b1;
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    alu_en = 1'b1;
                    InstrDone = 1'b1;
                    next = FETCH;
                end
                MEM_WB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                    InstrDone = 1'b1;
                    next = FETCH;
                end
                R_EXEC: begin
                    ALUSrcA = 1'b1;
                    aluop = AC_FUNCT;
                    alu_en = 1'b1;
                    next = R_WB;
                end
                R_WB: begin
                    RegDst = 1'b1;
                    RegWrite = 1'b1;
                    InstrDone = 1'b1;
                    next = FETCH;
                end
                I_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    aluop = op == OP_SLTI ? AC_SLT : AC_ADD;
                    alu_en = 1'b1;
                    next = I_WB;
                end
                I_WB: begin
                    RegWrite = 1'b1;
                    InstrDone = 1'b1;
                    next = FETCH;
                end
                BRANCH: begin
                    ALUSrcA = 1'b1;
                    aluop = AC_SUB;
                    alu_en = 1'b1;
                    PCWriteCond = 1'b1;
                    PCSrc = 2'b10;
                    InstrDone = 1'b1;
                    next = FETCH;
                end
                JUMP: begin
                    PCWrite = 1'b1;
                    PCSrc = 2'b01;
                    InstrDone = 1'b1;
                    next = FETCH;
                end
                JAL: begin
                    PCWrite = 1'b1;
                    PCSrc = 2'b01;
                    WriteRegSel = 1'b1;
                    WriteDataSel = 1'b1;
                    RegWrite = 1'b1;
                    InstrDone = 1'b1;
                    next = FETCH;
                end
                JR: begin
                    PCWrite = 1'b1;
                    PCSrc = 2'b11;
                    InstrDone = 1'b1;
                    next = FETCH;
                end
                HALT: begin
                    Halted = 1'b1;
                    next = HALT;
                end
                default: next = FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb_mips_multicycle_controller: directed and random instruction streams checked against a per-cycle control table
module tb_mips_multicycle_controller;
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       wr_sel;
        logic       mem_to_reg;
        logic       wd_sel;
        logic       reg_write;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] pc_src;
        logic [2:0] alu;
        logic       done;
        logic       halted;
    } ctl_t;

    logic clk, rst;
    logic [31:0] instr;
    logic [20:0] o1, o0;
    int checks = 0;
    int errors = 0;

    mips_multicycle_controller #(.TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst(rst), .Instruction(instr),
        .PCWrite(o1[20]), .PCWriteCond(o1[19]), .IorD(o1[18]), .MemRead(o1[17]),
        .MemWrite(o1[16]), .IRWrite(o1[15]), .RegDst(o1[14]), .WriteRegSel(o1[13]),
        .MemtoReg(o1[12]), .WriteDataSel(o1[11]), .RegWrite(o1[10]), .ALUSrcA(o1[9]),
        .ALUSrcB(o1[8:7]), .PCSrc(o1[6:5]), .ALUoperation(o1[4:2]),
        .InstrDone(o1[1]), .Halted(o1[0])
    );

    mips_multicycle_controller #(.TRAP_ON_ILLEGAL(1'b0)) dut_nop (
        .clk(clk), .rst(rst), .Instruction(instr),
        .PCWrite(o0[20]), .PCWriteCond(o0[19]), .IorD(o0[18]), .MemRead(o0[17]),
        .MemWrite(o0[16]), .IRWrite(o0[15]), .RegDst(o0[14]), .WriteRegSel(o0[13]),
        .MemtoReg(o0[12]), .WriteDataSel(o0[11]), .RegWrite(o0[10]), .ALUSrcA(o0[9]),
        .ALUSrcB(o0[8:7]), .PCSrc(o0[6:5]), .ALUoperation(o0[4:2]),
        .InstrDone(o0[1]), .Halted(o0[0])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_illegal(input logic [31:0] i);
        logic [5:0] op = i[31:26];
        logic [5:0] fn = i[5:0];
        if (!(op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h0A, 6'h23, 6'h2B})) return 1'b1;
        return op == 6'h00 && !(fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08});
    endfunction

    // total cycles including FETCH (illegal counts as the non-trapping FETCH+DECODE pair)
    function automatic int latency(input logic [31:0] i);
        logic [5:0] op = i[31:26];
        if (is_illegal(i)) return 2;
        if (op == 6'h23) return 5;
        if (op inside {6'h2B, 6'h08, 6'h0A}) return 4;
        if (op == 6'h00) return i[5:0] == 6'h08 ? 3 : 4;
        return 3;
    endfunction

    // expected control word in cycle k (0 = FETCH) of instruction i
    function automatic ctl_t model(input logic [31:0] i, input int k, input bit trap);
        ctl_t c = '0;
        logic [5:0] op = i[31:26];
        logic [5:0] fn = i[5:0];
        if (k == 0) begin
            c.mem_read = 1'b1; c.ir_write = 1'b1; c.pc_write = 1'b1; c.src_b = 2'b01; c.alu = 3'b010;
            return c;
        end
        if (k == 1) begin
            c.src_b = 2'b11; c.alu = 3'b010; c.done = is_illegal(i) && !trap;
            return c;
        end
        if (is_illegal(i)) begin
            c.halted = 1'b1;
            return c;
        end
        c.done = k == latency(i) - 1;
        case (op)
            6'h23, 6'h2B: begin
                if (k < 4) begin c.src_a = 1'b1; c.src_b = 2'b10; c.alu = 3'b010; end
                if (k == 3) begin c.iord = 1'b1; c.mem_read = op == 6'h23; c.mem_write = op == 6'h2B; end
                if (k == 4) begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
            end
            6'h00: begin
                if (fn == 6'h08) begin c.pc_write = 1'b1; c.pc_src = 2'b11; end
                else if (k == 2) begin
                    c.src_a = 1'b1;
                    c.alu = fn == 6'h20 ? 3'b010 : fn == 6'h22 ? 3'b110 : fn == 6'h24 ? 3'b000 :
                            fn == 6'h25 ? 3'b001 : 3'b111;
                end
                else begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
            end
            6'h08, 6'h0A: begin
                if (k == 2) begin c.src_a = 1'b1; c.src_b = 2'b10; c.alu = op == 6'h0A ? 3'b111 : 3'b010; end
                else c.reg_write = 1'b1;
            end
            6'h04: begin c.src_a = 1'b1; c.alu = 3'b110; c.pc_write_cond = 1'b1; c.pc_src = 2'b10; end
            6'h02: begin c.pc_write = 1'b1; c.pc_src = 2'b01; end
            default: begin
                c.pc_write = 1'b1; c.pc_src = 2'b01; c.wr_sel = 1'b1; c.wd_sel = 1'b1; c.reg_write = 1'b1;
            end
        endcase
        return c;
    endfunction

    task automatic chk(input string tag, input logic [20:0] obs, input ctl_t e);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    // drive instruction i through its first n cycles; starts and ends just after a posedge
    task automatic run_n(input logic [31:0] i, input int n);
        for (int k = 0; k < n; k++) begin
            if (k == 0) instr = i;
            @(negedge clk);
            chk($sformatf("trap %h k%0d", i, k), o1, model(i, k, 1'b1));
            chk($sformatf("nop %h k%0d", i, k), o0, model(i, k, 1'b0));
            @(posedge clk); #1;
        end
    endtask

    task automatic run(input logic [31:0] i);
        run_n(i, latency(i));
    endtask

    task automatic reset_cycles(input int n);
        rst = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("reset trap", o1, '0);
            chk("reset nop", o0, '0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    // illegal instruction: trapping DUT halts, non-trapping DUT loops FETCH/DECODE
    task automatic run_illegal(input logic [31:0] i);
        run_n(i, 2);
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            chk($sformatf("halt %h c%0d", i, j), o1, model(i, 2, 1'b1));
            chk($sformatf("nop loop %h c%0d", i, j), o0, model(i, j % 2, 1'b0));
            @(posedge clk); #1;
        end
        reset_cycles(1);
    endtask

    initial begin
        logic [5:0] ops [9];
        logic [5:0] fns [5];
        logic [5:0] op, fn;
        logic [31:0] i;
        int sel;
        ops = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h04, 6'h02, 6'h03, 6'h08, 6'h0A};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        rst = 1'b1;
        instr = 32'h0;
        @(posedge clk); #1;
        reset_cycles(2);
        run(32'h8C820004);
        run(32'h00432022);
        run(32'h0043202A);
        run(32'h00432024);
        run(32'h00432025);
        run(32'h00432020);
        run(32'h10430003);
        run(32'h0C000010);
        run(32'h03E00008);
        run(32'h08000040);
        run(32'h2042FFFF);
        run(32'h28430005);
        run(32'hAC820008);
        run_n(32'hAC820008, 3);
        reset_cycles(2);
        run(32'h8C820004);
        run_illegal(32'hFC000000);
        run_illegal(32'h00432007);
        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 9);
            i = $urandom;
            if (sel < 9) begin
                i[31:26] = ops[sel];
                if (sel == 2) i[5:0] = fns[$urandom_range(0, 4)];
                if (sel == 3) i[5:0] = 6'h08;
                run(i);
            end
            else begin
                if ($urandom_range(0, 1) == 0) begin
                    op = 6'($urandom);
                    while (op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h0A, 6'h23, 6'h2B}) op = 6'($urandom);
                    i[31:26] = op;
                end
                else begin
                    fn = 6'($urandom);
                    while (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08}) fn = 6'($urandom);
                    i[31:26] = 6'h00;
                    i[5:0] = fn;
                end
                run_illegal(i);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
